sgpr_lsu_wb_seq: RTL and testbench

Write-side sequencer for the 512x32b scalar register file: accepts one scalar-memory load return of 1, 2, 4, 8 or 16 dwords and drives the 128/64/32-bit write port (wr0) with aligned beats. It sits between the LSU return path and the SGPR array's wr0 port. It checks alignment, splits 8/16-dword returns into 128-bit beats, honours a stall from SGPR port arbitration, and reports completion or error per request.

---
 rtl/sgpr_lsu_wb_seq.sv | 157 +++++++++++++++
 tb/tb_sgpr_lsu_wb_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgpr_lsu_wb_seq.sv
// sgpr_lsu_wb_seq
// Write-side sequencer between the LSU scalar-load return path and the
// wr0 port of the 512x32b SGPR array. Takes one return of 1/2/4/8/16
// dwords, checks base alignment, and issues it as 1, 2 or 4 aligned
// 128-bit beats, holding while the port arbiter stalls.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_addr   [8:0]    base SGPR dword address
//   i_req_dwords [4:0]    dword count (1,2,4,8,16 legal)
//   i_req_data   [511:0]  return data, dword i at [32i+31:32i]
//   i_req_wfid   [5:0]    wavefront id, echoed on o_rsp_wfid
//   i_wb_stall            wr0 port unavailable this cycle
//   o_wr0_addr/en/data    SGPR write port
//   o_done_valid          pulse on the final issued beat
//   o_err_valid           pulse the cycle after an illegal request
//   o_rsp_wfid   [5:0]    wfid qualified by done/err
//
// state   | meaning
// IDLE    | ready for a request; may be reporting an error
// WRITE   | issuing beats r_beat..r_last of the held request
module sgpr_lsu_wb_seq (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic [8:0]   i_req_addr,
   input  logic [4:0]   i_req_dwords,
   input  logic [511:0] i_req_data,
   input  logic [5:0]   i_req_wfid,
   input  logic         i_wb_stall,
   output logic [8:0]   o_wr0_addr,
   output logic [3:0]   o_wr0_en,
   output logic [127:0] o_wr0_data,
   output logic         o_done_valid,
   output logic         o_err_valid,
   output logic [5:0]   o_rsp_wfid
);

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [8:0]     r_addr;
   logic [511:0]   r_data;
   logic [5:0]     r_wfid;
   logic [1:0]     r_beat;
   logic [1:0]     r_last;
   logic [3:0]     r_pat;
   logic           r_err;

   logic           w_accept;
   logic           w_legal;
   logic [1:0]     w_last_nxt;
   logic [3:0]     w_pat_nxt;
   logic [15:0]    w_keep;
   logic [511:0]   w_data_masked;
   logic           w_beat_done;
   logic           w_final;

   assign o_req_ready = (r_state == ST_IDLE) & ~i_rst;
   assign w_accept    = i_req_valid & o_req_ready;
   assign o_err_valid = r_err;
   assign o_rsp_wfid  = r_wfid;

   // Size decode: legality, last beat index, enable pattern, and which
   // dwords survive into the holding register (1/2-dword returns must
   // present zeros in the unused lanes of their single beat).
   always_comb begin
      w_legal    = 1'b0;
      w_last_nxt = 2'd0;
      w_pat_nxt  = 4'b1111;
      w_keep     = 16'hFFFF;
      case (i_req_dwords)
         5'd1: begin
            w_legal   = 1'b1;
            w_pat_nxt = 4'b0001;
            w_keep    = 16'h0001;
         end
         5'd2: begin
            w_legal   = ~i_req_addr[0];
            w_pat_nxt = 4'b0011;
            w_keep    = 16'h0003;
         end
         5'd4: begin
            w_legal = (i_req_addr[1:0] == 2'd0);
            w_keep  = 16'h000F;
         end
         5'd8: begin
            w_legal    = (i_req_addr[2:0] == 3'd0);
            w_last_nxt = 2'd1;
            w_keep     = 16'h00FF;
         end
         5'd16: begin
            w_legal    = (i_req_addr[3:0] == 4'd0);
            w_last_nxt = 2'd3;
         end
         default: w_legal = 1'b0;
      endcase
   end

   for (genvar g = 0; g < 16; g++) begin : g_mask
      assign w_data_masked[32*g +: 32] = w_keep[g] ? i_req_data[32*g +: 32] : 32'd0;
   end

   assign w_beat_done = (r_state == ST_WRITE) & ~i_wb_stall;
   assign w_final     = w_beat_done & (r_beat == r_last);

   always_comb begin
      w_state_nxt  = r_state;
      o_wr0_en     = 4'b0000;
      o_wr0_addr   = 9'd0;
      o_wr0_data   = 128'd0;
      o_done_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_legal) w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            o_wr0_en     = r_pat & {4{~i_wb_stall}};
            o_wr0_addr   = r_addr + {5'd0, r_beat, 2'b00};
            o_wr0_data   = r_data[{r_beat, 7'd0} +: 128];
            o_done_valid = w_final;
            if (w_final) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_addr  <= 9'd0;
         r_data  <= 512'd0;
         r_wfid  <= 6'd0;
         r_beat  <= 2'd0;
         r_last  <= 2'd0;
         r_pat   <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_accept & ~w_legal;
         if (w_accept) begin
            r_addr <= i_req_addr;
            r_data <= w_data_masked;
            r_wfid <= i_req_wfid;
            r_beat <= 2'd0;
            r_last <= w_last_nxt;
            r_pat  <= w_pat_nxt;
         end else if (w_beat_done && !w_final) begin
            r_beat <= r_beat + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_sgpr_lsu_wb_seq.sv
module tb_sgpr_lsu_wb_seq;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_req_valid = 1'b0;
   logic         o_req_ready;
   logic [8:0]   i_req_addr = '0;
   logic [4:0]   i_req_dwords = '0;
   logic [511:0] i_req_data = '0;
   logic [5:0]   i_req_wfid = '0;
   logic         i_wb_stall = 1'b0;
   logic [8:0]   o_wr0_addr;
   logic [3:0]   o_wr0_en;
   logic [127:0] o_wr0_data;
   logic         o_done_valid;
   logic         o_err_valid;
   logic [5:0]   o_rsp_wfid;

   sgpr_lsu_wb_seq dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(i_req_addr), .i_req_dwords(i_req_dwords),
      .i_req_data(i_req_data), .i_req_wfid(i_req_wfid),
      .i_wb_stall(i_wb_stall),
      .o_wr0_addr(o_wr0_addr), .o_wr0_en(o_wr0_en), .o_wr0_data(o_wr0_data),
      .o_done_valid(o_done_valid), .o_err_valid(o_err_valid),
      .o_rsp_wfid(o_rsp_wfid)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // sampled outputs of the most recent cycle
   logic         s_ready, s_done, s_err;
   logic [3:0]   s_en;
   logic [8:0]   s_addr;
   logic [127:0] s_data;
   logic [5:0]   s_wfid;

   // reference model: a queue of beats still owed to the SGPR
   typedef struct {
      logic [8:0]   addr;
      logic [3:0]   en;
      logic [127:0] data;
      bit           last;
      logic [5:0]   wfid;
   } beat_t;
   beat_t      q[$];
   bit         err_pend = 0;
   logic [5:0] err_wfid = '0;

   typedef struct {
      logic [4:0] dw;
      logic [8:0] addr;
      logic [5:0] wfid;
      bit         exp_err;
      int         exp_beats;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [511:0] rnd_data();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_accept(input logic [8:0] a, input logic [4:0] d,
                               input logic [511:0] dat, input logic [5:0] w);
      logic [31:0] words[16];
      int n, nb;
      n = int'(d);
      if (!(n == 1 || n == 2 || n == 4 || n == 8 || n == 16) || (int'(a) % n) != 0) begin
         err_pend = 1;
         err_wfid = w;
         return;
      end
      for (int i = 0; i < 16; i++) words[i] = (i < n) ? dat[32*i +: 32] : 32'd0;
      nb = (n + 3) / 4;
      for (int k = 0; k < nb; k++) begin
         beat_t b;
         b.addr = a + 9'(4*k);
         b.en   = (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
         b.data = {words[4*k+3], words[4*k+2], words[4*k+1], words[4*k]};
         b.last = (k == nb - 1);
         b.wfid = w;
         q.push_back(b);
      end
   endtask

   task automatic cycle(input bit v, input logic [8:0] a, input logic [4:0] d,
                        input logic [511:0] dat, input logic [5:0] w, input bit st);
      bit exp_ready, exp_done;
      logic [5:0] exp_wfid;
      i_req_valid  = v;
      i_req_addr   = a;
      i_req_dwords = d;
      i_req_data   = dat;
      i_req_wfid   = w;
      i_wb_stall   = st;
      @(negedge i_clk);
      s_ready = o_req_ready; s_done = o_done_valid; s_err = o_err_valid;
      s_en = o_wr0_en; s_addr = o_wr0_addr; s_data = o_wr0_data; s_wfid = o_rsp_wfid;
      exp_ready = (q.size() == 0);
      exp_done  = 0;
      exp_wfid  = err_wfid;
      chk("ready", s_ready, exp_ready);
      if (q.size() > 0) begin
         chk("en", s_en, st ? 4'b0000 : q[0].en);
         chk("addr", s_addr, q[0].addr);
         chk("data", s_data, q[0].data);
         exp_done = !st && q[0].last;
         if (exp_done) exp_wfid = q[0].wfid;
      end else begin
         chk("en_idle", s_en, 4'b0000);
      end
      chk("done", s_done, exp_done);
      chk("err", s_err, err_pend);
      if (err_pend || exp_done) chk("wfid", s_wfid, exp_wfid);
      if (q.size() > 0 && !st) void'(q.pop_front());
      err_pend = 0;
      if (v && exp_ready) model_accept(a, d, dat, w);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, '0, 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_en"}, o_wr0_en, 4'b0000);
      chk({nm, "_addr"}, o_wr0_addr, 9'd0);
      chk({nm, "_data"}, o_wr0_data, 128'd0);
      chk({nm, "_done"}, o_done_valid, 1'b0);
      chk({nm, "_err"}, o_err_valid, 1'b0);
      chk({nm, "_wfid"}, o_rsp_wfid, 6'd0);
   endtask

   initial begin
      logic [511:0] dat;
      int n_en;
      bit seen_done;

      tbl[0]  = '{5'd2,  9'h005, 6'd1,  1, 0};
      tbl[1]  = '{5'd4,  9'h006, 6'd2,  1, 0};
      tbl[2]  = '{5'd3,  9'h000, 6'd3,  1, 0};
      tbl[3]  = '{5'd1,  9'h1FF, 6'd4,  0, 1};
      tbl[4]  = '{5'd2,  9'h00A, 6'd5,  0, 1};
      tbl[5]  = '{5'd16, 9'h008, 6'd6,  1, 0};
      tbl[6]  = '{5'd8,  9'h0F8, 6'd7,  0, 2};
      tbl[7]  = '{5'd16, 9'h100, 6'd8,  0, 4};
      tbl[8]  = '{5'd0,  9'h000, 6'd9,  1, 0};
      tbl[9]  = '{5'd31, 9'h000, 6'd10, 1, 0};
      tbl[10] = '{5'd8,  9'h1F4, 6'd11, 1, 0};
      tbl[11] = '{5'd4,  9'h1FC, 6'd12, 0, 1};

      // reset state
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("rst_ready", o_req_ready, 1'b0);
      chk_reset_vals("rst");
      @(posedge i_clk); #1;
      i_rst = 0;
      idle(1);

      // 1 dword at 0x013
      dat = rnd_data();
      dat[31:0] = 32'hDEADBEEF;
      cycle(1, 9'h013, 5'd1, dat, 6'd21, 0);
      cycle(0, '0, '0, '0, '0, 0);
      chk("d1_en", s_en, 4'b0001);
      chk("d1_addr", s_addr, 9'h013);
      chk("d1_data", s_data, {96'd0, 32'hDEADBEEF});
      chk("d1_done", s_done, 1'b1);
      chk("d1_wfid", s_wfid, 6'd21);
      idle(1);

      // 16 dwords at 0x1F0, another request waiting the whole burst
      for (int i = 0; i < 16; i++) dat[32*i +: 32] = i;
      cycle(1, 9'h1F0, 5'd16, dat, 6'd33, 0);
      for (int k = 0; k < 4; k++) begin
         cycle(1, 9'h033, 5'd1, rnd_data(), 6'd7, 0);
         chk("d16_addr", s_addr, 9'h1F0 + 9'(4*k));
         chk("d16_en", s_en, 4'b1111);
         chk("d16_ready", s_ready, 1'b0);
         chk("d16_done", s_done, k == 3);
      end
      chk("d16_b3data", s_data, {32'd15, 32'd14, 32'd13, 32'd12});
      idle(3);

      // 8 dwords at 0x020, stall on beat 1
      cycle(1, 9'h020, 5'd8, rnd_data(), 6'd44, 0);
      cycle(0, '0, '0, '0, '0, 0);
      chk("d8_b0addr", s_addr, 9'h020);
      cycle(0, '0, '0, '0, '0, 1);
      chk("d8_stall_en", s_en, 4'b0000);
      chk("d8_stall_addr", s_addr, 9'h024);
      chk("d8_stall_done", s_done, 1'b0);
      cycle(0, '0, '0, '0, '0, 0);
      chk("d8_b1en", s_en, 4'b1111);
      chk("d8_b1addr", s_addr, 9'h024);
      chk("d8_done", s_done, 1'b1);
      idle(1);

      // 2 dwords at 0x00A
      dat = rnd_data();
      dat[63:0] = 64'h22222222_11111111;
      cycle(1, 9'h00A, 5'd2, dat, 6'd50, 0);
      cycle(0, '0, '0, '0, '0, 0);
      chk("d2_en", s_en, 4'b0011);
      chk("d2_addr", s_addr, 9'h00A);
      chk("d2_data", s_data, {64'd0, 64'h22222222_11111111});
      idle(1);

      // legality table
      foreach (tbl[j]) begin
         cycle(1, tbl[j].addr, tbl[j].dw, rnd_data(), tbl[j].wfid, 0);
         cycle(0, '0, '0, '0, '0, 0);
         chk("tbl_err_t1", s_err, tbl[j].exp_err);
         if (tbl[j].exp_err) chk("tbl_err_wfid", s_wfid, tbl[j].wfid);
         n_en = (s_en != 0) ? 1 : 0;
         seen_done = s_done;
         for (int c = 0; c < 5; c++) begin
            cycle(0, '0, '0, '0, '0, 0);
            if (s_en != 0) n_en++;
            if (s_done) seen_done = 1;
         end
         chk("tbl_beats", n_en, tbl[j].exp_beats);
         chk("tbl_done", seen_done, !tbl[j].exp_err);
      end

      // reset during beat 2 of a 16-dword burst
      cycle(1, 9'h040, 5'd16, rnd_data(), 6'd60, 0);
      cycle(0, '0, '0, '0, '0, 0);
      cycle(0, '0, '0, '0, '0, 0);
      i_rst = 1;
      i_req_valid = 0;
      i_wb_stall = 0;
      @(negedge i_clk);
      chk("mid_rst_ready", o_req_ready, 1'b0);
      @(posedge i_clk); #1;
      i_rst = 0;
      q.delete();
      err_pend = 0;
      @(negedge i_clk);
      chk_reset_vals("mid_rst");
      chk("mid_rst_ready1", o_req_ready, 1'b1);
      @(posedge i_clk); #1;
      idle(4);

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         logic [4:0] d;
         logic [8:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1: d = 5'd1;
            2:    d = 5'd2;
            3:    d = 5'd4;
            4, 5: d = 5'd8;
            6, 7: d = 5'd16;
            8:    d = 5'd3;
            default: d = 5'($urandom_range(0, 31));
         endcase
         a = 9'($urandom);
         if ($urandom_range(0, 3) != 0) a = a & ~9'h00F;
         cycle($urandom_range(0, 2) != 0, a, d, rnd_data(), 6'($urandom),
               $urandom_range(0, 9) < 3);
      end
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
